// File: rtl/pipo_inv_s_layer_pipe.sv
// Pipelined PIPO inverse bitsliced S-layer (8 columns of 8-bit inverse S-box) with valid/ready flow control.
// Optional output self-check against a forward S-layer: define PIPO_INV_SLAYER_SELFCHECK_EN.
module pipo_inv_s_layer_pipe #(
  parameter int unsigned PIPE_STAGES       = 3,
  parameter bit          FLUSH_CLEARS_DATA = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0][7:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0][7:0] out_state,
  output logic            busy,
  output logic            selfcheck_err
);

  localparam int unsigned NS = (PIPE_STAGES == 32'd1) ? 32'd1 : 32'd3;

  typedef logic [7:0][7:0] state_t;

  // Undo the truncate XOR / bit change and the S5_2 layer.
  function automatic state_t inv_s1(input state_t y);
    state_t     e;
    logic [7:0] a6, t0, t1, t2;
    e    = y;
    e[7] = y[0];
    e[3] = y[6];
    e[4] = y[5];
    e[5] = y[4] ^ (y[3] | y[5]);
    a6   = y[3] ^ (y[5] | y[6]);
    e[6] = a6 ^ (e[7] & e[5]);
    t0   = e[7] ^ a6;
    t1   = e[3] ^ e[5];
    t2   = e[4] ^ (t1 & t0);
    e[1] = y[7] ^ t2;
    e[0] = y[1] ^ t1;
    e[2] = y[2] ^ t0;
    return e;
  endfunction

  // Undo the extend XOR, then the 3-bit S-box including the X[2] complement.
  function automatic state_t inv_s2(input state_t e);
    state_t     c;
    logic [7:0] c2p;
    c    = e;
    c[7] = e[7] ^ e[1];
    c[3] = e[3] ^ e[2];
    c[4] = e[4] ^ e[0];
    c2p  = ~e[2];
    c[1] = e[1] ^ (c2p | e[0]);
    c[0] = e[0] ^ (c2p | c[1]);
    c[2] = c2p ^ (c[1] & c[0]);
    return c;
  endfunction

  // Undo S5_1 on the upper five rows.
  function automatic state_t inv_s3(input state_t c);
    state_t     b;
    logic [7:0] b4p, b5p;
    b    = c;
    b4p  = c[4] ^ (c[5] & c[6]);
    b5p  = c[5] ^ c[7];
    b[3] = c[3] ^ (b4p | b5p);
    b[6] = c[6] ^ b[3];
    b[7] = c[7] ^ b4p;
    b[4] = b4p ^ (b[3] & b5p);
    b[5] = b5p ^ (b[7] & b[6]);
    return b;
  endfunction

  function automatic state_t stage_fn(input int unsigned idx, input state_t x);
    state_t r;
    if (NS == 32'd1) r = inv_s3(inv_s2(inv_s1(x)));
    else if (idx == 32'd0) r = inv_s1(x);
    else if (idx == 32'd1) r = inv_s2(x);
    else r = inv_s3(x);
    return r;
  endfunction

  logic [NS-1:0] v;
  state_t        d     [NS];
  logic [NS-1:0] rdy;
  logic [NS-1:0] src_v;
  state_t        src_d [NS];
  state_t        nxt   [NS];

  // A stage may load when it or any later stage has room, or the sink accepts.
  always_comb begin
    for (int unsigned i = 0; i < NS; i++) begin
      rdy[i] = out_ready;
      for (int unsigned j = i; j < NS; j++) begin
        if (!v[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign in_ready = rdy[0] & ~flush;

  always_comb begin
    src_v[0] = in_valid & in_ready;
    src_d[0] = in_state;
    for (int unsigned i = 1; i < NS; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
    for (int unsigned i = 0; i < NS; i++) begin
      nxt[i] = stage_fn(i, src_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int unsigned i = 0; i < NS; i++) d[i] <= '0;
    end else if (flush) begin
      v <= '0;
      if (FLUSH_CLEARS_DATA) begin
        for (int unsigned i = 0; i < NS; i++) d[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NS; i++) begin
        if (rdy[i]) begin
          v[i] <= src_v[i];
          if (src_v[i]) d[i] <= nxt[i];
        end
      end
    end
  end

  assign out_valid = v[NS-1];
  assign out_state = d[NS-1];
  assign busy      = |v;

`ifdef PIPO_INV_SLAYER_SELFCHECK_EN
  function automatic state_t fwd_s(input state_t x);
    state_t     s;
    logic [7:0] t0, t1, t2;
    s = x;
    s[5] = s[5] ^ (s[7] & s[6]);
    s[4] = s[4] ^ (s[3] & s[5]);
    s[7] = s[7] ^ s[4];
    s[6] = s[6] ^ s[3];
    s[3] = s[3] ^ (s[4] | s[5]);
    s[5] = s[5] ^ s[7];
    s[4] = s[4] ^ (s[5] & s[6]);
    s[2] = s[2] ^ (s[1] & s[0]);
    s[0] = s[0] ^ (s[2] | s[1]);
    s[1] = s[1] ^ (s[2] | s[0]);
    s[2] = ~s[2];
    s[7] = s[7] ^ s[1];
    s[3] = s[3] ^ s[2];
    s[4] = s[4] ^ s[0];
    t0 = s[7];
    t1 = s[3];
    t2 = s[4];
    s[6] = s[6] ^ (t0 & s[5]);
    t0   = t0 ^ s[6];
    s[6] = s[6] ^ (t2 | t1);
    t1   = t1 ^ s[5];
    s[5] = s[5] ^ (s[6] | t2);
    t2   = t2 ^ (t1 & t0);
    s[2] = s[2] ^ t0;
    t0   = s[1] ^ t2;
    s[1] = s[0] ^ t1;
    s[0] = s[7];
    s[7] = t0;
    t1   = s[3];
    s[3] = s[6];
    s[6] = t1;
    t2   = s[4];
    s[4] = s[5];
    s[5] = t2;
    return s;
  endfunction

  state_t sh     [NS];
  state_t sh_src [NS];
  logic   err;
  logic   mismatch;

  always_comb begin
    sh_src[0] = in_state;
    for (int unsigned i = 1; i < NS; i++) sh_src[i] = sh[i-1];
    mismatch = (fwd_s(d[NS-1]) != sh[NS-1]);
  end

  // Shadows follow the data registers' load enables exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NS; i++) sh[i] <= '0;
      err <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NS; i++) sh[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NS; i++) begin
        if (rdy[i] && src_v[i]) sh[i] <= sh_src[i];
      end
      if (out_valid && out_ready && mismatch) err <= 1'b1;
    end
  end

  assign selfcheck_err = err;
`else
  assign selfcheck_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipo_inv_s_layer_pipe.sv
// Bench for pipo_inv_s_layer_pipe: directed flow-control steps plus a random stream against a table model.
module tb_pipo_inv_s_layer_pipe;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy, selfcheck_err;
  logic [63:0] in_state, out_state;

  int cmp_n = 0;
  int err_n = 0;

  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];
  logic [63:0] exp_q [$];
  logic [63:0] org_q [$];
  bit          mon_en = 1'b1;

  always #5 clk = ~clk;

  pipo_inv_s_layer_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_state      (in_state),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_state     (out_state),
    .busy          (busy),
    .selfcheck_err (selfcheck_err)
  );

  // Forward PIPO S-box on one column, bit 7 = X[7].
  function automatic logic [7:0] fwd8(input logic [7:0] v);
    logic [7:0] x;
    logic t0, t1, t2;
    x = v;
    x[5] ^= x[7] & x[6]; x[4] ^= x[3] & x[5]; x[7] ^= x[4]; x[6] ^= x[3];
    x[3] ^= x[4] | x[5]; x[5] ^= x[7]; x[4] ^= x[5] & x[6];
    x[2] ^= x[1] & x[0]; x[0] ^= x[2] | x[1]; x[1] ^= x[2] | x[0]; x[2] = ~x[2];
    x[7] ^= x[1]; x[3] ^= x[2]; x[4] ^= x[0];
    t0 = x[7]; t1 = x[3]; t2 = x[4];
    x[6] ^= t0 & x[5]; t0 ^= x[6]; x[6] ^= t2 | t1; t1 ^= x[5];
    x[5] ^= x[6] | t2; t2 ^= t1 & t0;
    x[2] ^= t0; t0 = x[1] ^ t2; x[1] = x[0] ^ t1; x[0] = x[7]; x[7] = t0;
    t1 = x[3]; x[3] = x[6]; x[6] = t1; t2 = x[4]; x[4] = x[5]; x[5] = t2;
    return x;
  endfunction

  // Apply the forward or inverse table to each of the 8 bit-columns.
  function automatic logic [63:0] layer(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    logic [7:0]  c, o;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) c[k] = s[8*k+j];
      o = inv ? inv_tab[c] : fwd_tab[c];
      for (int k = 0; k < 8; k++) r[8*k+j] = o[k];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input string tag, input logic [63:0] s);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_state = s;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      in_valid = 1'b0;
      n++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_fwd"}, layer(out_state, 1'b0), s);
    step();
  endtask

  // Scoreboard: inputs accepted at the next edge are queued, outputs accepted are compared.
  always @(negedge clk) begin
    logic [63:0] e, o;
    if (!rst_n || flush) begin
      exp_q.delete();
      org_q.delete();
    end else begin
      if (out_valid && out_ready && mon_en) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          o = org_q.pop_front();
          check("out_data", out_state, e);
          check("fwd_roundtrip", layer(out_state, 1'b0), o);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(layer(in_state, 1'b1));
        org_q.push_back(in_state);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] vals [5];
    logic [63:0] outs [5];
    logic [63:0] st [5];
    logic [63:0] hold;
    int first, last, got, acc, ov, sent;

    for (int i = 0; i < 256; i++) fwd_tab[i] = fwd8(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_state", out_state, 64'd0);
    check("rst_selfcheck", 64'(selfcheck_err), 64'd0);
    step(); step();
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single zero state latency.
    measure_latency("t1", 64'h0);

    // Back-to-back stream, last entry is FWD_S of a known value.
    vals[0] = 64'h0123456789ABCDEF; vals[1] = 64'hFFFFFFFFFFFFFFFF;
    vals[2] = 64'h8000000000000001; vals[3] = 64'hA5A5A5A55A5A5A5A;
    vals[4] = layer(64'h0123456789ABCDEF, 1'b0);
    out_ready = 1'b1; first = -1; last = -1; got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      in_valid = (c < 5);
      if (c < 5) in_state = vals[c];
      #1;
      if (c < 5) check("t2_in_ready", 64'(in_ready), 64'd1);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        outs[got] = out_state;
        got++;
      end
      step();
    end
    in_valid = 1'b0;
    check("t2_count", 64'(got), 64'd5);
    check("t2_first", 64'(first), 64'(LAT));
    check("t2_consecutive", 64'(last - first), 64'd4);
    check("t2_known_inverse", outs[4], 64'h0123456789ABCDEF);

    // Stall: only the pipeline depth is accepted while out_ready is low.
    for (int i = 0; i < 5; i++) st[i] = {$urandom, $urandom};
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) in_state = st[acc];
      #1;
      if (in_valid && in_ready) acc++;
      step();
    end
    check("t3_accepted", 64'(acc), 64'd3);
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    check("t3_out_valid", 64'(out_valid), 64'd1);
    hold = out_state;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t3_hold", out_state, hold);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (acc < 5 || busy); c++) begin
      in_valid = (acc < 5);
      if (acc < 5) in_state = st[acc];
      #1;
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    check("t3_all_accepted", 64'(acc), 64'd5);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Flush one cycle after the second accept; an input offered during flush is dropped.
    out_ready = 1'b1; in_valid = 1'b1; in_state = {$urandom, $urandom};
    step();
    in_state = {$urandom, $urandom};
    step();
    in_state = {$urandom, $urandom}; flush = 1'b1;
    #1;
    check("t4_in_ready_flush", 64'(in_ready), 64'd0);
    check("t4_no_out_flush", 64'(out_valid), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_busy_after", 64'(busy), 64'd0);
    ov = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) ov++;
    end
    check("t4_no_out", 64'(ov), 64'd0);
    measure_latency("t4_after", {$urandom, $urandom});

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_state = {$urandom, $urandom};
      step();
    end
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_out_state", out_state, 64'd0);
    in_valid = 1'b0;
    step(); step();
    #2 rst_n = 1'b1;
    ov = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) ov++;
    end
    check("t5_no_stale", 64'(ov), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);

    // Random valid/ready stream.
    sent = 0;
    for (int c = 0; c < 20000 && (sent < 1000 || busy); c++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_state  = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t6_sent", 64'(sent), 64'd1000);
    check("t6_idle", 64'(busy), 64'd0);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    check("t6_selfcheck", 64'(selfcheck_err), 64'd0);

`ifdef PIPO_INV_SLAYER_SELFCHECK_EN
    // Corrupt one stage-2 bit of a zero input; its correct stage-2 value is 64'hFFFF.
    mon_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_state = 64'h0;
    step();
    in_valid = 1'b0;
    step();
    force dut.d[1] = 64'h000000000000FFFE;
    step();
    release dut.d[1];
    step();
    check("t7_err_set", 64'(selfcheck_err), 64'd1);
    step(); step(); step();
    check("t7_err_sticky", 64'(selfcheck_err), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; mon_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/pipo_inv_s_layer_pipe.md
Name: pipo_inv_s_layer_pipe

Overview:
- Pipelined inverse S-layer for the PIPO-64/128 decryption datapath; exact inverse of the PIPO forward bitsliced S-layer.
- Takes a 64-bit state (state_t, 8 bytes X[7]..X[0]) and applies the inverse 8-bit PIPO S-box to each of the 8 bit-columns. Column j is formed from bit j of each byte, with X[7] as MSb.
- Three register stages with a valid/ready handshake, so the decryption round controller can stall it.
- Sits between the inverse R-layer and the round-key XOR in the decrypt round.

Parameters:
- PIPE_STAGES, 3, number of register stages; legal values 1 or 3. With 1, all logic sits before a single output register.
- FLUSH_CLEARS_DATA, 1, 1 = flush also zeroes stage data registers; 0 = only valid bits are cleared.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; aborts the in-flight decrypt.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept input this cycle.
- in_state  in  64  state_t, byte 7 = X[7].
- out_valid  out  1  out_state valid.
- out_ready  in  1  downstream accepts.
- out_state  out  64  inverse-S-layer result, same byte layout.
- busy  out  1  any stage holds valid data.
- selfcheck_err  out  1  sticky mismatch flag; only meaningful with the optional feature, otherwise tied 0.

Behaviour:
- Function: out_state = INV_S(in_state), where for every state x, INV_S(FWD_S(x)) == x and FWD_S(INV_S(x)) == x. The mapping is purely per column; columns are independent.
- Stage split for PIPE_STAGES=3:
  - S1: undo bit-change/truncate XOR and the S5_2 layer.
  - S2: undo the extend XOR and S3, including the complement of X[2].
  - S3: undo S5_1, ending with the X[5] ^= X[7]&X[6] inverse.
  - Each stage is a register holding valid plus 64-bit data.
- Latency: 3 cycles from accepted input (in_valid & in_ready) to out_valid, when not stalled. PIPE_STAGES=1 gives 1 cycle.
- Throughput: 1 state/cycle when out_ready=1.
- Handshake:
  - Transfer occurs when valid & ready are both high on the same rising edge.
  - in_ready = ~v_last | out_ready, chained per stage: a stage advances if the next stage is empty or advancing. in_ready is combinational from out_ready; there is no ready bubble.
  - Once out_valid=1, out_state is held stable until accepted.
  - in_state is sampled only on a transfer.
- Stall: with out_ready=0 and the pipe full, in_ready=0, and all data is held unchanged.
- Bubbles: an empty middle stage is collapsed — upstream data advances into it even while out_ready=0.
- Simultaneous input accept and output accept when full: both happen; occupancy is unchanged.
- flush:
  - On the next edge all valid bits clear to 0. Data is also cleared if FLUSH_CLEARS_DATA=1.
  - in_ready is forced to 0 during the flush cycle. An input presented that cycle is dropped.
  - flush overrides out_ready; an output presented in the flush cycle is not considered transferred.
- Reset (rst_n=0, asynchronous): all valid bits 0, all data 0, out_valid=0, out_state=0, busy=0, selfcheck_err=0. in_ready becomes 1 once reset deasserts. Reset mid-operation discards in-flight states.
- busy = OR of all stage valid bits.
- No X-propagation from the data path to the control path. The valid/ready logic is independent of data.

Optional Feature:
- Macro: PIPO_INV_SLAYER_SELFCHECK_EN.
- Defined:
  - Each stage carries a shadow copy of the original in_state.
  - At the output, a combinational forward S-layer is applied to out_state and compared to the shadow.
  - On any accepted output (out_valid & out_ready) with a mismatch, selfcheck_err is set. It stays sticky until rst_n.
  - Shadows are cleared with flush and reset.
- Undefined: no shadow registers; selfcheck_err is constant 0.
- Function and latency are identical either way.

Test Plan:
- Reset, then in_state=64'h0, out_ready=1 -> out_valid high exactly 3 cycles after acceptance; FWD_S(out_state)==64'h0. in_ready=1 throughout.
- Stream the 4 states 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 64'hA5A5A5A55A5A5A5A back-to-back with out_ready=1 -> 4 outputs on 4 consecutive cycles, in order, each satisfying FWD_S(out)==in. Also feed FWD_S(64'h0123456789ABCDEF) -> out_state==64'h0123456789ABCDEF.
- Hold out_ready=0 and push 5 states -> only 3 accepted; in_ready=0 afterwards; out_state stable for 10 cycles. Release out_ready -> outputs 1,2,3 appear, then states 4 and 5 are accepted.
- Send 2 states, assert flush 1 cycle after the second is accepted -> no out_valid ever for either; busy=0 the cycle after flush. A new state then emerges with 3-cycle latency.
- Assert rst_n=0 asynchronously mid-stream (between edges) -> out_valid, busy drop immediately; no stale output after release.
- With PIPO_INV_SLAYER_SELFCHECK_EN and 1000 random states -> selfcheck_err stays 0. Force one stage-2 data bit via the bench -> selfcheck_err=1 on that output and stays 1.
